// File: rtl/adc_scan_averager.sv
// adc_scan_averager
//
// Round-robin channel scanner and boxcar averager for the LTC2308 serial ADC interface.
// Presents a channel select to the ADC, drops the first (stale) result after each channel
// change, sums 2^AVG_LOG2 results and emits their truncated mean with a one-cycle strobe.
//
// Ports:
//   clk         system clock, shared with the ADC interface
//   reset_n     asynchronous active-low reset, shared with the ADC interface
//   enable      scan request, sampled on capture cycles only
//   adc_result  12-bit conversion result from the ADC interface
//   chan        registered channel select to the ADC interface
//   ch_data     averaged sample, held between strobes
//   ch_idx      channel number of ch_data, held between strobes
//   ch_valid    one-cycle strobe marking a new ch_data/ch_idx
//   scan_done   one-cycle strobe coincident with ch_valid for the last channel
module adc_scan_averager #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [11:0] adc_result,
    output logic [2:0]  chan,
    output logic [11:0] ch_data,
    output logic [2:0]  ch_idx,
    output logic        ch_valid,
    output logic        scan_done
);

    localparam int unsigned FcntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned AccW  = 12 + AVG_LOG2;
    localparam int unsigned CntW  = AVG_LOG2 + 1;

    localparam logic [FcntW-1:0] LastFcnt = FcntW'(FRAME_LEN - 1);
    localparam logic [CntW-1:0]  LastCnt  = CntW'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]       LastCh   = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDiscard,
        StAccum
    } state_e;

    state_e            state_q, state_d;
    logic [FcntW-1:0]  fcnt_q;
    logic [2:0]        chan_q, chan_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [11:0]       ch_data_q, ch_data_d;
    logic [2:0]        ch_idx_q, ch_idx_d;
    logic              ch_valid_q, ch_valid_d;
    logic              scan_done_q, scan_done_d;

    logic              capture;
    logic [AccW-1:0]   acc_sum;

    // The ADC interface runs the same free-running count off the same reset, so a capture
    // here lines up with the end of its conversion frame.
    assign capture = (fcnt_q == LastFcnt);

    // Width AccW holds 2^AVG_LOG2 full-scale samples exactly, so this sum cannot wrap.
    assign acc_sum = acc_q + AccW'(adc_result);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
        end else if (capture) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FcntW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ch_data_d   = ch_data_q;
        ch_idx_d    = ch_idx_q;
        ch_valid_d  = 1'b0;
        scan_done_d = 1'b0;

        if (capture) begin
            case (state_q)
                StIdle: begin
                    chan_d = '0;
                    if (enable) begin
                        state_d = StDiscard;
                    end
                end
                // The result landing now was converted on the previous channel: drop it.
                StDiscard: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
                StAccum: begin
                    if (cnt_q == LastCnt) begin
                        // Mean = sum >> AVG_LOG2, truncated; take the bit slice directly.
                        ch_data_d   = acc_sum[AVG_LOG2 +: 12];
                        ch_idx_d    = chan_q;
                        ch_valid_d  = 1'b1;
                        scan_done_d = (chan_q == LastCh);
                        if (enable) begin
                            chan_d  = (chan_q == LastCh) ? 3'd0 : chan_q + 3'd1;
                            state_d = StDiscard;
                        end else begin
                            chan_d  = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    chan_d  = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            chan_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ch_data_q   <= '0;
            ch_idx_q    <= '0;
            ch_valid_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ch_data_q   <= ch_data_d;
            ch_idx_q    <= ch_idx_d;
            ch_valid_q  <= ch_valid_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign chan      = chan_q;
    assign ch_data   = ch_data_q;
    assign ch_idx    = ch_idx_q;
    assign ch_valid  = ch_valid_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_adc_scan_averager.sv
// Bench for adc_scan_averager: default instance (8 ch, 4-sample mean) and a 3-channel,
// single-sample instance. Inputs change at frame starts; expected strobes (index, data,
// scan_done, arrival cycle) are queued when a channel's samples are driven and compared
// when ch_valid appears.
module tb_adc_scan_averager;

    typedef struct {
        int idx;
        int data;
        int done;
        int at;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        enable_a;
    logic        enable_b;
    logic [11:0] adc;

    logic [2:0]  chan_a, ch_idx_a, chan_b, ch_idx_b;
    logic [11:0] ch_data_a, ch_data_b;
    logic        ch_valid_a, scan_done_a, ch_valid_b, scan_done_b;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t q_a[$];
    exp_t q_b[$];

    adc_scan_averager u_dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable_a),
        .adc_result(adc),
        .chan      (chan_a),
        .ch_data   (ch_data_a),
        .ch_idx    (ch_idx_a),
        .ch_valid  (ch_valid_a),
        .scan_done (scan_done_a)
    );

    adc_scan_averager #(
        .NUM_CH   (3),
        .AVG_LOG2 (0),
        .FRAME_LEN(16)
    ) u_dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable_b),
        .adc_result(adc),
        .chan      (chan_b),
        .ch_data   (ch_data_b),
        .ch_idx    (ch_idx_b),
        .ch_valid  (ch_valid_b),
        .scan_done (scan_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; equals the DUT frame count modulo 16.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (ch_valid_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", ch_valid_a, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_idx",  ch_idx_a,    e.idx);
                    check("a_data", ch_data_a,   e.data);
                    check("a_done", scan_done_a, e.done);
                    check("a_time", cyc,         e.at);
                end
            end else begin
                check("a_done_without_valid", scan_done_a, 0);
            end
            if (ch_valid_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", ch_valid_b, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_idx",  ch_idx_b,    e.idx);
                    check("b_data", ch_data_b,   e.data);
                    check("b_done", scan_done_b, e.done);
                    check("b_time", cyc,         e.at);
                end
            end else begin
                check("b_done_without_valid", scan_done_b, 0);
            end
        end
    end

    // One conversion frame; called at the negedge of an fcnt==0 cycle.
    task automatic frame(input logic [11:0] v);
        adc = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic push(input bit b, input int idx, input int data, input int done,
                        input int at);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.done = done;
        e.at   = at;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    // One channel: a discarded frame then nacc frames of base + k*step.
    task automatic run_ch(input bit b, input int idx, input int nacc, input int lg,
                          input int num_ch, input logic [11:0] disc, input int base,
                          input int step);
        int sum;
        sum = 0;
        for (int k = 0; k < nacc; k++) sum += base + k * step;
        push(b, idx, sum >> lg, (idx == num_ch - 1) ? 1 : 0, cyc + 16 * (nacc + 1));
        check(b ? "b_chan" : "a_chan", b ? chan_b : chan_a, idx);
        frame(disc);
        for (int k = 0; k < nacc; k++) frame(12'(base + k * step));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        adc      = '0;
        repeat (3) @(negedge clk);
        check("rst_chan",      chan_a,      0);
        check("rst_data",      ch_data_a,   0);
        check("rst_idx",       ch_idx_a,    0);
        check("rst_valid",     ch_valid_a,  0);
        check("rst_scan_done", scan_done_a, 0);
        check("rst_chan_b",    chan_b,      0);

        // Full default scan: first strobe at cycle 96, last (with scan_done) at 656.
        reset_n  = 1'b1;
        enable_a = 1'b1;
        frame(12'h123);
        run_ch(0, 0, 4, 2, 8, 12'h7FF, 'h800, 0);
        run_ch(0, 1, 4, 2, 8, 12'd7,   1,     1);   // discarded 7, then 1..4 -> 2
        run_ch(0, 2, 4, 2, 8, 12'h000, 'hFFF, 0);   // full-scale, no wrap
        for (int i = 3; i < 8; i++) run_ch(0, i, 4, 2, 8, 12'h555, 'h800 + i * 16, 3);

        // Second scan; enable dropped during the 2nd accumulate frame of channel 3.
        for (int i = 0; i < 3; i++) run_ch(0, i, 4, 2, 8, 12'hAAA, 'h100 * i + 5, 7);
        push(0, 3, (10 + 20 + 30 + 41) >> 2, 0, cyc + 80);
        check("a_chan", chan_a, 3);
        frame(12'hABC);
        frame(12'd10);
        adc = 12'd20;
        repeat (8) @(negedge clk);
        enable_a = 1'b0;
        repeat (8) @(negedge clk);
        frame(12'd30);
        frame(12'd41);
        check("a_chan_after_stop", chan_a, 0);
        frame(12'hFFF);
        frame(12'hFFF);
        frame(12'hFFF);
        check("a_chan_idle",      chan_a,    0);
        check("a_data_held",      ch_data_a, 25);
        check("a_idx_held",       ch_idx_a,  3);
        check("a_q_drained_stop", q_a.size(), 0);

        // Reset mid-accumulate on channel 5.
        enable_a = 1'b1;
        frame(12'h000);
        for (int i = 0; i < 5; i++) run_ch(0, i, 4, 2, 8, 12'h333, 'h200 + i, 1);
        check("a_chan", chan_a, 5);
        frame(12'h999);
        frame(12'h444);
        frame(12'h444);
        adc = 12'h444;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_chan",      chan_a,      0);
        check("mid_rst_data",      ch_data_a,   0);
        check("mid_rst_idx",       ch_idx_a,    0);
        check("mid_rst_valid",     ch_valid_a,  0);
        check("mid_rst_scan_done", scan_done_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        frame(12'h000);
        enable_a = 1'b0;  // only the final capture sees it: channel 0 completes, then idle
        run_ch(0, 0, 4, 2, 8, 12'h111, 'h0F0, 5);
        frame(12'h000);
        check("a_chan_idle2", chan_a, 0);

        // Three channels, one sample each: strobes every 32 clocks.
        enable_b = 1'b1;
        frame(12'h000);
        run_ch(1, 0, 1, 0, 3, 12'h111, 'h321, 0);
        run_ch(1, 1, 1, 0, 3, 12'h222, 'hABC, 0);
        run_ch(1, 2, 1, 0, 3, 12'h333, 'h00F, 0);
        enable_b = 1'b0;
        run_ch(1, 0, 1, 0, 3, 12'h444, 'hFFE, 0);
        frame(12'h000);
        frame(12'h000);
        check("b_chan_idle", chan_b, 0);

        check("a_q_drained", q_a.size(), 0);
        check("b_q_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
